// File: rtl/up_sample_pkg.sv
// Shared types and geometry for the 2x nearest-neighbour up-sample scheduler.
// Default frame geometry; the top re-derives these from its own parameters.
package up_sample_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    localparam int IN_W_DEF       = 64;
    localparam int IN_H_DEF       = 64;
    localparam int SCALE_LOG2_DEF = 1;
    localparam int CW_DEF         = 16;

    localparam int OW    = IN_W_DEF << SCALE_LOG2_DEF;
    localparam int OH    = IN_H_DEF << SCALE_LOG2_DEF;
    localparam int IDX_W = $clog2(IN_W_DEF * IN_H_DEF) + 1;

endpackage

// File: rtl/raster_counter.sv
// Row/column raster walker over a W x H extent; sticks at the last
// position once the final increment has been taken.
module raster_counter #(
    parameter int W  = 64,
    parameter int H  = 64,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_row,
    output logic [CW-1:0] o_col,
    output logic          o_last,
    output logic          o_done
);

    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_done;
    logic          w_col_end;

    assign w_col_end = (r_col == CW'(W - 1));
    assign o_last    = w_col_end && (r_row == CW'(H - 1));
    assign o_row     = r_row;
    assign o_col     = r_col;
    assign o_done    = r_done;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_row  <= '0;
            r_col  <= '0;
            r_done <= 1'b0;
        end else if (i_inc && !r_done) begin
            if (o_last) begin
                r_done <= 1'b1;
            end else if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + CW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/up_sample_schedule_ctrl.sv
// Write/read schedule for the input-stencil buffer of the 2x up-sampler;
// reads are gated until their source input pixel has been written.
module up_sample_schedule_ctrl
    import up_sample_pkg::*;
#(
    parameter int IN_W       = IN_W_DEF,
    parameter int IN_H       = IN_H_DEF,
    parameter int SCALE_LOG2 = SCALE_LOG2_DEF,
    parameter int CW         = CW_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    output logic               o_wen,
    output logic [2:0][CW-1:0] o_write_ctrl_vars,
    output logic               o_ren,
    output logic [2:0][CW-1:0] o_read_ctrl_vars,
    output logic               o_out_valid,
    input  logic               i_out_ready
);

    localparam int L_OW  = IN_W << SCALE_LOG2;
    localparam int L_OH  = IN_H << SCALE_LOG2;
    localparam int L_IDX = $clog2(IN_W * IN_H) + 1;

    ctrl_state_t      r_state;
    logic [L_IDX-1:0] r_wr_count;

    logic             w_rst;
    logic             w_clr;
    logic             w_run;
    logic             w_wen;
    logic             w_ren;
    logic             w_rd_adv;
    logic             w_dep_ok;
    logic [L_IDX-1:0] w_src;
    logic [CW-1:0]    w_wr_row;
    logic [CW-1:0]    w_wr_col;
    logic [CW-1:0]    w_rd_row;
    logic [CW-1:0]    w_rd_col;
    logic             w_wr_last;
    logic             w_rd_last;
    logic             w_wr_done;
    logic             w_rd_done;
    logic             w_unused_last;

    assign w_rst = !i_rst_n || i_flush;
    assign w_clr = i_flush || ((r_state == IDLE) && i_start);
    assign w_run = (r_state == RUN);

    assign o_in_ready = w_run && !w_wr_done;
    assign w_wen      = i_in_valid && o_in_ready;

    // Source pixel of the current output position in input raster order.
    assign w_src = L_IDX'(w_rd_row >> SCALE_LOG2) * L_IDX'(IN_W)
                 + L_IDX'(w_rd_col >> SCALE_LOG2);

    assign w_dep_ok = (w_src < r_wr_count);
    assign w_ren    = w_run && !w_rd_done && w_dep_ok;
    assign w_rd_adv = w_ren && i_out_ready;

    assign o_wen       = w_wen;
    assign o_ren       = w_ren;
    assign o_out_valid = w_ren;
    assign o_busy      = w_run;
    assign o_done      = (r_state == DONE);

    assign o_write_ctrl_vars = {CW'(0), w_wr_row, w_wr_col};
    assign o_read_ctrl_vars  = {CW'(0), w_rd_row, w_rd_col};

    assign w_unused_last = w_wr_last & w_rd_last;

    raster_counter #(.W(IN_W), .H(IN_H), .CW(CW)) u_wr_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_inc   (w_wen),
        .o_row   (w_wr_row),
        .o_col   (w_wr_col),
        .o_last  (w_wr_last),
        .o_done  (w_wr_done)
    );

    raster_counter #(.W(L_OW), .H(L_OH), .CW(CW)) u_rd_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_inc   (w_rd_adv),
        .o_row   (w_rd_row),
        .o_col   (w_rd_col),
        .o_last  (w_rd_last),
        .o_done  (w_rd_done)
    );

    always_ff @(posedge i_clk) begin
        if (w_rst || w_clr) begin
            r_wr_count <= '0;
        end else if (w_wen) begin
            r_wr_count <= r_wr_count + L_IDX'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (i_start) r_state <= RUN;
                RUN:     if (w_wr_done && w_rd_done) r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/up_sample_schedule_ctrl.md
Name: up_sample_schedule_ctrl

Overview:
- Schedule controller for the 2x nearest-neighbour up-sample pipeline.
- Drives the write port (wen, ctrl_vars) of the input-stencil unified buffer from an input stream handshake.
- Drives the read port (ren, ctrl_vars) of the same buffer so the nearest-neighbour compute stage sees every output pixel in raster order.
- Enforces the producer/consumer dependency: a read issues only once its source input pixel has been written. Reports frame start, busy and done.

Parameters:
- IN_W, 64, input frame width in pixels.
- IN_H, 64, input frame height in pixels.
- SCALE_LOG2, 1, log2 of the up-sample factor; output is (IN_W<<SCALE_LOG2) x (IN_H<<SCALE_LOG2).
- CW, 16, width of each ctrl_vars element.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous frame abort; same effect as reset.
- start  in  1  begin a frame; honoured only in IDLE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the frame completes.
- in_valid  in  1  input pixel available.
- in_ready  out  1  controller accepts the input pixel.
- wen  out  1  input-stencil UB write enable.
- write_ctrl_vars  out  3 x CW  write loop indices {d0, row, col}.
- ren  out  1  input-stencil UB read enable.
- read_ctrl_vars  out  3 x CW  read loop indices {d0, row, col} in output coordinates.
- out_valid  in/out  out  1  read data on the UB read port is valid this cycle.
- out_ready  in  1  downstream compute stage consumes the pixel.

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous active-low.
- Reset (rst_n=0 or flush=1 at a clk edge):
  - state goes to IDLE.
  - All counters go to 0; wr_done and rd_done go to 0.
  - busy, done, in_ready, wen, ren and out_valid are 0.
  - Both ctrl_vars are all-zero.
- FSM states are IDLE, RUN and DONE.
  - IDLE: on start=1, clear counters and go to RUN next cycle.
  - RUN: when wr_done and rd_done are both set, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
  - start outside IDLE is ignored.
- Write side:
  - in_ready = (state==RUN) & ~wr_done. wen = in_valid & in_ready, combinational.
  - write_ctrl_vars = {0, wr_row, wr_col}, taken directly from registers.
  - On wen: wr_col increments. At IN_W-1 it wraps to 0 and wr_row increments.
  - On the write at (IN_H-1, IN_W-1): set wr_done and hold the counters.
  - wr_count (width clog2(IN_W*IN_H)+1) increments on each wen.
- Read side:
  - OW = IN_W<<SCALE_LOG2 and OH = IN_H<<SCALE_LOG2.
  - Source index src = (rd_row>>SCALE_LOG2)*IN_W + (rd_col>>SCALE_LOG2).
  - dep_ok = src < wr_count, using the registered wr_count. There is no same-cycle write-to-read bypass.
  - out_valid = ren = (state==RUN) & ~rd_done & dep_ok.
  - read_ctrl_vars = {0, rd_row, rd_col}. The UB read is combinational, so data is valid in the cycle ren is high (0 latency).
  - On ren & out_ready: rd_col increments. At OW-1 it wraps and rd_row increments.
  - The read at (OH-1, OW-1) sets rd_done.
  - While out_ready=0, rd_row, rd_col and ren are held stable.
- Concurrency: write and read advance independently in the same cycle. Sustained rate is 1 write/cycle and 1 read/cycle.
- Timing:
  - First read, (0,0), can issue no earlier than the cycle after the first wen.
  - Output row 2k stalls until input pixel (k, col>>1) has been written.
- Arithmetic: all counters are unsigned. ctrl_vars are zero-extended to CW. Counters never exceed their extents, so no overflow handling is needed.
- flush mid-frame aborts immediately: next cycle is IDLE with no done pulse. UB contents are don't-care.

Decomposition:
- Package up_sample_pkg holds:
  - state enum ctrl_state_t {IDLE, RUN, DONE};
  - localparams OW, OH, and IDX_W = clog2(IN_W*IN_H)+1.
- Sub-module raster_counter (params W, H, CW): inputs clk, rst_n, clr, inc; outputs row, col, last, done.
  - Instantiated twice: write side and read side.
  - Its clr input is driven by flush or by start in IDLE.

Test Plan:
- Full frame: start, then in_valid=1 and out_ready=1 continuously. Expect 4096 wen and 16384 ren, raster ctrl_vars, and read (5,7) addressing input (2,3). Exactly one done pulse, then IDLE.
- Dependency stall: write only input row 0 (64 pixels), then hold in_valid=0. Expect reads to complete output rows 0 and 1 (256 reads). ren=0 at read (2,0) until input (1,0) is written; first read occurs the cycle after that wen.
- First access: start, then a single wen at cycle t. Expect out_valid=0 at t and out_valid=1 with read_ctrl_vars={0,0,0} at t+1.
- Backpressure: out_ready=0 for 10 cycles mid-row at read (3,40). Expect ren held at 1 and read_ctrl_vars held at {0,3,40}; no advance; writes continue.
- flush at read (50,10): next cycle state IDLE with all outputs 0 and no done. A new start then runs a clean frame from (0,0).
- rst_n=0 for one cycle mid-RUN: same clearing as flush. start asserted in RUN/DONE has no effect on the counters.
